// File: rtl/fifo_reg_pkg.sv
// Shared constants and helpers for the register-based FIFO controller.
package fifo_reg_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_DEPTH  = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_reg_ctrl_if.sv
// Push side, slot-register side and output-stage signals of the FIFO controller.
interface fifo_reg_ctrl_if
    import fifo_reg_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic                    i_push;
    logic [DWIDTH-1:0]       i_wdata;
    logic                    o_full;
    logic [DEPTH-1:0]        o_wf;
    logic [DWIDTH-1:0]       o_wdata;
    logic [DEPTH*DWIDTH-1:0] i_slot_d;
    logic                    o_valid;
    logic                    i_ready;
    logic [DWIDTH-1:0]       ot_d;
    logic [AW:0]             o_count;
    logic                    o_ovf;

    modport slave (
        input  i_push, i_wdata, i_slot_d, i_ready,
        output o_full, o_wf, o_wdata, o_valid, ot_d, o_count, o_ovf
    );

    modport master (
        output i_push, i_wdata, i_slot_d, i_ready,
        input  o_full, o_wf, o_wdata, o_valid, ot_d, o_count, o_ovf
    );

endinterface

// File: rtl/fifo_slot_mux.sv
// Combinational DEPTH:1 select of the flattened slot contents by read pointer.
module fifo_slot_mux
    import fifo_reg_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic [DEPTH*DWIDTH-1:0] slot_d_i,
    input  logic [AW-1:0]           sel_i,
    output logic [DWIDTH-1:0]       data_o
);

    logic [DWIDTH-1:0] slots [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign slots[k] = slot_d_i[k*DWIDTH +: DWIDTH];
    end

    // DEPTH is a power of two, so every sel_i value names a real slot.
    assign data_o = slots[sel_i];

endmodule

// File: rtl/fifo_reg_ctrl.sv
// Pointer, occupancy and output-stage control for a FIFO whose storage lives in
// external slot registers; the oldest word is held in a registered valid/ready stage.
module fifo_reg_ctrl
    import fifo_reg_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    fifo_reg_ctrl_if.slave   bus
);

    localparam int AW = clog2(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [DWIDTH-1:0] rd_word;
    logic              full, push_ok, load;

    fifo_slot_mux #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mux (
        .slot_d_i (bus.i_slot_d),
        .sel_i    (rd_ptr_q),
        .data_o   (rd_word)
    );

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign push_ok = bus.i_push & ~full & ~rst;
    // cnt_q != 0 guarantees the slot being loaded was written at an earlier edge.
    assign load    = (~valid_q | bus.i_ready) & (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (load) begin
            data_d   = rd_word;
            rd_ptr_d = rd_ptr_q + 1'b1;
            valid_d  = 1'b1;
        end else if (valid_q & bus.i_ready) begin
            valid_d  = 1'b0;
        end
        case ({push_ok, load})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (bus.i_push & full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
        end
    end

    assign bus.o_full  = full;
    assign bus.o_wf    = push_ok ? (DEPTH'(1) << wr_ptr_q) : '0;
    assign bus.o_wdata = bus.i_wdata;
    assign bus.o_valid = valid_q;
    assign bus.ot_d    = data_q;
    assign bus.o_count = cnt_q + (AW+1)'(valid_q);
    assign bus.o_ovf   = ovf_q;

endmodule
